// File: rtl/pipe_de_exe.sv
// Decode-to-execute pipeline register with load-use bubble insertion and flush handling.
// Optional stall/flush performance counters are built only when PIPE_DE_EXE_PERF_CNT_EN is defined.
module pipe_de_exe #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr_de,
    input  logic [31:0]      pc_de,
    input  logic [31:0]      pc_4_de,
    input  logic [31:0]      rs1_data_de,
    input  logic [31:0]      rs2_data_de,
    input  logic             valid_de,
    input  logic             stall,
    input  logic             hazard,
    input  logic             fwd_a_sel,
    input  logic             fwd_b_sel,
    input  logic [31:0]      data_a_mgr,
    input  logic [31:0]      data_b_mgr,
    input  logic             flush,
    output logic             hold_de,
    output logic [31:0]      instr_exe,
    output logic [31:0]      pc_exe,
    output logic [31:0]      pc_4_exe,
    output logic [31:0]      data_a_exe,
    output logic [31:0]      data_b_exe,
    output logic             valid_exe
`ifdef PIPE_DE_EXE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_4_q, pc_4_d;
    logic [31:0] data_a_q, data_a_d;
    logic [31:0] data_b_q, data_b_d;
    logic        valid_q, valid_d;
    logic        insert_bubble;

    // Flush wins over stall; either one replaces the execute slot with a NOP.
    assign insert_bubble = flush | stall;
    assign hold_de       = stall & ~flush;

    always_comb begin
        state_d  = RUN;
        instr_d  = instr_de;
        pc_d     = pc_de;
        pc_4_d   = pc_4_de;
        data_a_d = (hazard & fwd_a_sel) ? data_a_mgr : rs1_data_de;
        data_b_d = (hazard & fwd_b_sel) ? data_b_mgr : rs2_data_de;
        valid_d  = valid_de;

        case (state_q)
            RUN:     state_d = stall ? BUBBLE : RUN;
            BUBBLE:  state_d = stall ? BUBBLE : RUN;
            default: state_d = RUN;
        endcase
        if (flush) begin
            state_d = RUN;
        end

        // Bubbles keep the PC of the last real instruction in execute.
        if (insert_bubble) begin
            instr_d  = NOP_INSTR;
            pc_d     = pc_q;
            pc_4_d   = pc_4_q;
            data_a_d = 32'h0;
            data_b_d = 32'h0;
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            instr_q  <= NOP_INSTR;
            pc_q     <= 32'h0;
            pc_4_q   <= 32'h0;
            data_a_q <= 32'h0;
            data_b_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            pc_4_q   <= pc_4_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            valid_q  <= valid_d;
        end
    end

    assign instr_exe  = instr_q;
    assign pc_exe     = pc_q;
    assign pc_4_exe   = pc_4_q;
    assign data_a_exe = data_a_q;
    assign data_b_exe = data_b_q;
    assign valid_exe  = valid_q;

`ifdef PIPE_DE_EXE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Both counters stick at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hold_de && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
